// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_pkg
//  Description : Shared definitions for the memory slave controller.
//                - Controller state encoding (IDLE, WAIT, RESP)
//                - Default data width, address width and depth
//                - Helper that sizes the storage word index
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_pkg;

  localparam int DEF_WIDTH      = 32;
  localparam int DEF_ADDR_WIDTH = 8;
  localparam int DEF_DEPTH      = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Bits needed to index DEPTH words. A single-word array still needs one bit.
  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_intr.sv
`default_nettype none
// ============================================================================
//  Module      : mem_intr
//  Description : Request/response bundle for the memory slave.
//                Master side drives valid, wr_rd, addr, wdata, wstrb.
//                Slave side drives rdata, ready, err.
//  Revision    : 1.1 - added wstrb and err
// ============================================================================
interface mem_intr #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 8
);
  logic                    valid;
  logic                    wr_rd;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [WIDTH-1:0]        wdata;
  logic [WIDTH/8-1:0]      wstrb;
  logic [WIDTH-1:0]        rdata;
  logic                    ready;
  logic                    err;

  modport master (output valid, wr_rd, addr, wdata, wstrb, input rdata, ready, err);
  modport slave  (input valid, wr_rd, addr, wdata, wstrb, output rdata, ready, err);
endinterface
`default_nettype wire

// File: rtl/mem_array.sv
`default_nettype none
// ============================================================================
//  Module      : mem_array
//  Description : Word storage with one synchronous byte-enabled write port
//                and one combinational read port. Contents are not reset.
//  Ports       : clk           - clock, writes on posedge
//                we            - write enable
//                waddr         - write word index
//                wdata / wstrb - write data and per-byte enables
//                raddr         - read word index
//                rdata         - combinational read data
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_array #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 64,
  parameter int IDX_W = 6
) (
  input  logic               clk,
  input  logic               we,
  input  logic [IDX_W-1:0]   waddr,
  input  logic [WIDTH-1:0]   wdata,
  input  logic [WIDTH/8-1:0] wstrb,
  input  logic [IDX_W-1:0]   raddr,
  output logic [WIDTH-1:0]   rdata
);

  localparam int C_BYTES = WIDTH / 8;

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < C_BYTES; b++) begin
        if (wstrb[b]) begin
          r_mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
        end
      end
    end
  end

  assign rdata = r_mem[raddr];

endmodule
`default_nettype wire

// File: rtl/mem_slave_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mem_slave_ctrl
//  Description : Single-port memory slave with configurable wait states.
//                A request is accepted in IDLE, optionally delayed in WAIT,
//                and answered with a one-cycle ready pulse in RESP.
//  Ports       : clk, rst (async, active-high)
//                valid, wr_rd, addr, wdata, wstrb - request from master
//                rdata, ready, err                - registered response
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_slave_ctrl
  import mem_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int DEPTH       = DEF_DEPTH,
  parameter int WAIT_STATES = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid,
  input  logic                  wr_rd,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic [WIDTH/8-1:0]    wstrb,
  output logic [WIDTH-1:0]      rdata,
  output logic                  ready,
  output logic                  err
);

  localparam int                  C_IDX_W    = idx_width(DEPTH);
  localparam logic [ADDR_WIDTH:0] C_DEPTH    = DEPTH[ADDR_WIDTH:0];
  localparam bit                  C_NO_WAIT  = (WAIT_STATES == 0);
  localparam logic [3:0]          C_CNT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_t                r_state;
  logic [3:0]            r_cnt;
  logic                  r_wr;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [WIDTH-1:0]      r_wdata;
  logic [WIDTH/8-1:0]    r_wstrb;

  // With no wait states the response is committed on the accept edge itself,
  // before the capture registers hold the request, so the live inputs are used
  // while in IDLE and the captured copy afterwards.
  logic                  w_in_idle;
  logic                  w_cur_wr;
  logic [ADDR_WIDTH-1:0] w_cur_addr;
  logic [WIDTH-1:0]      w_cur_wdata;
  logic [WIDTH/8-1:0]    w_cur_wstrb;
  logic                  w_in_range;
  logic                  w_enter_resp;
  logic                  w_we;
  logic [WIDTH-1:0]      w_rd_word;

  assign w_in_idle    = (r_state == IDLE);
  assign w_cur_wr     = w_in_idle ? wr_rd : r_wr;
  assign w_cur_addr   = w_in_idle ? addr  : r_addr;
  assign w_cur_wdata  = w_in_idle ? wdata : r_wdata;
  assign w_cur_wstrb  = w_in_idle ? wstrb : r_wstrb;
  assign w_in_range   = ({1'b0, w_cur_addr} < C_DEPTH);

  assign w_enter_resp = (w_in_idle && valid && C_NO_WAIT) ||
                        ((r_state == WAIT) && (r_cnt == 4'd0));

  // Out-of-range requests never touch the array.
  assign w_we = w_enter_resp && w_cur_wr && w_in_range;

  mem_array #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .IDX_W (C_IDX_W)
  ) u_mem_array (
    .clk   (clk),
    .we    (w_we),
    .waddr (w_cur_addr[C_IDX_W-1:0]),
    .wdata (w_cur_wdata),
    .wstrb (w_cur_wstrb),
    .raddr (w_cur_addr[C_IDX_W-1:0]),
    .rdata (w_rd_word)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_wr    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_wstrb <= '0;
      ready   <= 1'b0;
      err     <= 1'b0;
      rdata   <= '0;
    end else begin
      // ready and err are single-cycle pulses; only the RESP entry sets them.
      ready <= 1'b0;
      err   <= 1'b0;

      if (w_enter_resp) begin
        ready <= 1'b1;
        err   <= ~w_in_range;
        // rdata only changes on read responses, so it holds across writes.
        if (!w_cur_wr) begin
          rdata <= w_in_range ? w_rd_word : '0;
        end
      end

      case (r_state)
        IDLE: begin
          if (valid) begin
            r_wr    <= wr_rd;
            r_addr  <= addr;
            r_wdata <= wdata;
            r_wstrb <= wstrb;
            if (C_NO_WAIT) begin
              r_state <= RESP;
            end else begin
              r_state <= WAIT;
              r_cnt   <= C_CNT_LOAD;
            end
          end
        end
        WAIT: begin
          if (r_cnt == 4'd0) begin
            r_state <= RESP;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        RESP: begin
          // Unconditional return: a request still presented here waits for IDLE.
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_slave_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_slave_ctrl
//  Description : Self-checking bench for mem_slave_ctrl. Two instances:
//                bus_a/dut_a with two wait states, bus_b/dut_b with none.
//                Expected responses come from a word/byte-mask memory model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_slave_ctrl;

  localparam int WIDTH = 32;
  localparam int AW    = 8;
  localparam int DEPTH = 64;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_intr #(.WIDTH(WIDTH), .ADDR_WIDTH(AW)) bus_a ();
  mem_intr #(.WIDTH(WIDTH), .ADDR_WIDTH(AW)) bus_b ();

  mem_slave_ctrl #(.WIDTH(WIDTH), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .WAIT_STATES(2)) dut_a (
    .clk   (clk),
    .rst   (rst),
    .valid (bus_a.valid),
    .wr_rd (bus_a.wr_rd),
    .addr  (bus_a.addr),
    .wdata (bus_a.wdata),
    .wstrb (bus_a.wstrb),
    .rdata (bus_a.rdata),
    .ready (bus_a.ready),
    .err   (bus_a.err)
  );

  mem_slave_ctrl #(.WIDTH(WIDTH), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .WAIT_STATES(0)) dut_b (
    .clk   (clk),
    .rst   (rst),
    .valid (bus_b.valid),
    .wr_rd (bus_b.wr_rd),
    .addr  (bus_b.addr),
    .wdata (bus_b.wdata),
    .wstrb (bus_b.wstrb),
    .rdata (bus_b.rdata),
    .ready (bus_b.ready),
    .err   (bus_b.err)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: word contents plus a mask of bytes ever written.
  logic [31:0] m_mem   [2][DEPTH];
  logic [3:0]  m_known [2][DEPTH];
  logic [31:0] m_lr    [2];
  logic [3:0]  m_lr_k  [2];
  int          ws      [2] = '{2, 0};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] bmask(input logic [3:0] k);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) m[b*8 +: 8] = {8{k[b]}};
    return m;
  endfunction

  task automatic drive(input int sel, input logic v, input logic wr, input logic [7:0] a,
                       input logic [31:0] d, input logic [3:0] s);
    if (sel == 0) begin
      bus_a.valid = v; bus_a.wr_rd = wr; bus_a.addr = a; bus_a.wdata = d; bus_a.wstrb = s;
    end else begin
      bus_b.valid = v; bus_b.wr_rd = wr; bus_b.addr = a; bus_b.wdata = d; bus_b.wstrb = s;
    end
  endtask

  function automatic logic get_ready(input int sel);
    return (sel == 0) ? bus_a.ready : bus_b.ready;
  endfunction

  function automatic logic get_err(input int sel);
    return (sel == 0) ? bus_a.err : bus_b.err;
  endfunction

  function automatic logic [31:0] get_rdata(input int sel);
    return (sel == 0) ? bus_a.rdata : bus_b.rdata;
  endfunction

  // Issue one request at the current negedge and check its response.
  // b2b: driven in the visible response cycle of the previous request, so
  //      acceptance slips by one cycle. hold: leave valid high for the next call.
  task automatic run_txn(input int sel, input logic wr, input int a, input logic [31:0] d,
                         input logic [3:0] s, input bit b2b, input bit hold);
    int n;
    bit got;
    int exp_lat;
    bit oor;
    exp_lat = ws[sel] + 1 + (b2b ? 1 : 0);
    drive(sel, 1'b1, wr, 8'(a), d, s);
    n = 0;
    got = 0;
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      if (get_ready(sel)) got = 1;
      else if (n == 1 && !b2b)
        // Request already captured; later input changes must not matter.
        drive(sel, 1'b1, 1'($urandom), 8'($urandom), $urandom, 4'($urandom));
    end
    check("latency", 64'(n), 64'(exp_lat));

    oor = (a >= DEPTH);
    if (oor) begin
      if (!wr) begin
        m_lr[sel]   = 32'h0;
        m_lr_k[sel] = 4'hF;
      end
    end else if (wr) begin
      for (int b = 0; b < 4; b++)
        if (s[b]) m_mem[sel][a][b*8 +: 8] = d[b*8 +: 8];
      m_known[sel][a] = m_known[sel][a] | s;
    end else begin
      m_lr[sel]   = m_mem[sel][a];
      m_lr_k[sel] = m_known[sel][a];
    end
    check("err", 64'(get_err(sel)), 64'(oor));
    check("rdata", 64'(get_rdata(sel) & bmask(m_lr_k[sel])), 64'(m_lr[sel] & bmask(m_lr_k[sel])));

    if (!hold) begin
      drive(sel, 1'b0, 1'b0, 8'h0, 32'h0, 4'h0);
      @(negedge clk);
      check("pulse_end", {62'h0, get_ready(sel), get_err(sel)}, 64'h0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    int rs;
    int ra;
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < DEPTH; i++) begin
        m_mem[s][i]   = 32'h0;
        m_known[s][i] = 4'h0;
      end
      m_lr[s]   = 32'h0;
      m_lr_k[s] = 4'hF;
    end

    rst = 1'b1;
    drive(0, 1'b0, 1'b0, 8'h0, 32'h0, 4'h0);
    drive(1, 1'b0, 1'b0, 8'h0, 32'h0, 4'h0);
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      check("rst_ready", 64'(get_ready(s)), 64'h0);
      check("rst_err", 64'(get_err(s)), 64'h0);
      check("rst_rdata", 64'(get_rdata(s)), 64'h0);
    end
    rst = 1'b0;
    @(negedge clk);

    // Full write then read back.
    run_txn(0, 1'b1, 5, 32'hDEADBEEF, 4'hF, 0, 0);
    run_txn(0, 1'b0, 5, 32'h0, 4'h0, 0, 0);
    check("dir_rd5", 64'(bus_a.rdata), 64'hDEADBEEF);

    // Partial write over existing data.
    run_txn(0, 1'b1, 5, 32'h00001234, 4'h3, 0, 0);
    run_txn(0, 1'b0, 5, 32'h0, 4'h0, 0, 0);
    check("dir_merge", 64'(bus_a.rdata), 64'hDEAD1234);

    // Out of range read, then a normal read.
    run_txn(0, 1'b0, 70, 32'h0, 4'h0, 0, 0);
    run_txn(0, 1'b0, 5, 32'h0, 4'h0, 0, 0);
    check("dir_after_oor", 64'(bus_a.rdata), 64'hDEAD1234);

    // Zero-strobe write leaves memory alone.
    run_txn(0, 1'b1, 3, 32'hA5A5A5A5, 4'hF, 0, 0);
    run_txn(0, 1'b1, 3, 32'h5A5A5A5A, 4'h0, 0, 0);
    run_txn(0, 1'b0, 3, 32'h0, 4'h0, 0, 0);
    check("dir_strb0", 64'(bus_a.rdata), 64'hA5A5A5A5);

    // Reset during WAIT of a write aborts it.
    run_txn(0, 1'b1, 9, 32'h11111111, 4'hF, 0, 0);
    drive(0, 1'b1, 1'b1, 8'd9, 32'h22222222, 4'hF);
    @(negedge clk);
    #1 rst = 1'b1;
    #1 check("rst_async_rdata", 64'(bus_a.rdata), 64'h0);
    check("rst_async_ready", 64'(bus_a.ready), 64'h0);
    repeat (2) begin
      @(negedge clk);
      check("rst_hold_ready", 64'(bus_a.ready), 64'h0);
    end
    drive(0, 1'b0, 1'b0, 8'h0, 32'h0, 4'h0);
    rst = 1'b0;
    for (int s = 0; s < 2; s++) begin
      m_lr[s]   = 32'h0;
      m_lr_k[s] = 4'hF;
    end
    repeat (4) begin
      @(negedge clk);
      check("abort_no_ready", 64'(bus_a.ready), 64'h0);
    end
    run_txn(0, 1'b0, 9, 32'h0, 4'h0, 0, 0);
    check("dir_abort_rd9", 64'(bus_a.rdata), 64'h11111111);

    // Zero wait states, valid held across four writes then four reads.
    for (int i = 0; i < 4; i++)
      run_txn(1, 1'b1, 20 + i, 32'hC0DE0000 + 32'(i), 4'hF, i != 0, i != 3);
    for (int i = 0; i < 4; i++) begin
      run_txn(1, 1'b0, 20 + i, 32'h0, 4'h0, i != 0, i != 3);
    end
    check("b2b_last", 64'(bus_b.rdata), 64'hC0DE0003);

    // Randomized traffic on both instances.
    for (int i = 0; i < 80; i++) begin
      rs = int'($urandom_range(0, 1));
      ra = ($urandom_range(0, 9) == 0) ? int'($urandom_range(64, 79)) : int'($urandom_range(0, 15));
      run_txn(rs, 1'($urandom), ra, $urandom, 4'($urandom), 0, 0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_slave_ctrl.md
MEM_SLAVE_CTRL -- requirements
Module: mem_slave_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data width in bits; a multiple of 8.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, address width in bits.
REQ-003 SHALL have parameter DEPTH, default 64, number of words; DEPTH <= 2**ADDR_WIDTH.
REQ-004 SHALL have parameter WAIT_STATES, default 0, extra cycles inserted before a response; range 0..15.
REQ-005 SHALL have port clk, input, 1, single clock; all logic on posedge.
REQ-006 SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-007 SHALL have port valid, input, 1, request present; held by the master until ready.
REQ-008 SHALL have port wr_rd, input, 1, 1 = write, 0 = read.
REQ-009 SHALL have port addr, input, ADDR_WIDTH, word address.
REQ-010 SHALL have port wdata, input, WIDTH, write data.
REQ-011 SHALL have port wstrb, input, WIDTH/8, byte enables for writes; bit i enables byte i.
REQ-012 SHALL have port rdata, output, WIDTH, read data.
REQ-013 SHALL have port ready, output, 1, single-cycle completion pulse.
REQ-014 SHALL have port err, output, 1, error flag, valid only while ready=1.

Function
REQ-015 SHALL implement a three-state FSM: IDLE, WAIT, RESP.
REQ-016 IDLE: if valid=1 at posedge, SHALL capture wr_rd/addr/wdata/wstrb, then go to WAIT if WAIT_STATES>0 (load counter with WAIT_STATES-1), otherwise go to RESP.
REQ-017 WAIT: SHALL decrement the counter each cycle and go to RESP when the counter equals 0.
REQ-018 RESP: SHALL assert ready=1 for exactly one cycle, then return to IDLE unconditionally.
REQ-019 Latency: SHALL raise ready exactly 1+WAIT_STATES cycles after the accept edge.
REQ-020 Writes SHALL update only the bytes enabled by wstrb, at the edge that enters RESP; wstrb=0 SHALL complete with no change.
REQ-021 Reads SHALL drive rdata with mem[addr] in the ready cycle.
REQ-022 rdata SHALL hold its last read value through idle periods and write responses.
REQ-023 Input changes after the accept edge SHALL be ignored until the FSM returns to IDLE.
REQ-024 Out of range (captured addr >= DEPTH): no array access, err=1 with ready; a read SHALL return rdata=0.
REQ-025 err SHALL be 0 whenever ready=0.
REQ-026 Back-to-back requests: valid still high in the RESP cycle SHALL NOT be accepted; acceptance SHALL resume at the first IDLE edge, so there is a minimum of one idle cycle between responses.
REQ-027 Read-after-write to the same address SHALL return the newly written data.

Reset
REQ-028 rst=1 SHALL asynchronously force state=IDLE, counter=0, ready=0, err=0, rdata=0.
REQ-029 Reset mid-transaction SHALL abort it: no write is committed and no ready is issued.
REQ-030 Array contents SHALL NOT be reset; reads of unwritten locations are undefined and unchecked.

Structure
REQ-031 Shared package mem_pkg SHALL hold the state enum (IDLE, WAIT, RESP) and the default WIDTH/ADDR_WIDTH/DEPTH constants.
REQ-032 Storage SHALL be a sub-module mem_array: one synchronous byte-enabled write port and one combinational read port.
REQ-033 The existing mem_intr interface SHALL be extended with wstrb and err for the bench.

Verification (WIDTH=32, DEPTH=64, WAIT_STATES=2 unless stated)
REQ-034 Write addr=5, wdata=32'hDEADBEEF, wstrb=4'hF, then read addr=5 -> ready exactly 3 cycles after each accept; rdata=32'hDEADBEEF, err=0.
REQ-035 Write addr=5, wdata=32'h00001234, wstrb=4'h3 over 32'hDEADBEEF, then read -> rdata=32'hDEAD1234.
REQ-036 Read addr=70 -> ready after 3 cycles with err=1 and rdata=0; the following read of addr=5 returns its stored value with err=0.
REQ-037 Assert rst during WAIT of a write to addr=9 (previously 32'h11111111) -> ready stays 0; a later read of addr=9 returns 32'h11111111.
REQ-038 WAIT_STATES=0, valid held high for four requests -> each ready 1 cycle after its accept, at least one idle cycle between responses, no request dropped or duplicated.
REQ-039 Write addr=3 with wstrb=4'h0 -> ready=1, err=0, memory unchanged.
